// File: rtl/regfile_mp.sv
// Multi-port register file with a pending-producer scoreboard and a post-reset clearing sweep.
// Build option: define REGFILE_BYPASS_EN to forward the write-port data to both read ports in the same cycle.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  output logic              rs1_pend_o,
  output logic              rs2_pend_o,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              reg_write_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  output logic              ready_o
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZERO  = (ZERO_REG != 0);
  localparam logic [ADDR_W-1:0] LAST = '1;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DEPTH-1:0]  pend;
  logic [DATA_W-1:0] mem [DEPTH];

  logic wr_ok;
  logic al_ok;

  always_comb begin
    wr_ok = (state == READY) && reg_write_i && !(ZERO && (rd_addr_i == '0));
    al_ok = (state == READY) && alloc_i && !(ZERO && (alloc_addr_i == '0));
  end

  // Alloc is applied after the write clear so a same-address pair leaves the entry pending.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CLEAR;
      cnt   <= '0;
      pend  <= '0;
    end else if (state == CLEAR) begin
      cnt <= cnt + 1'b1;
      if (cnt == LAST) state <= READY;
    end else begin
      if (wr_ok) pend[rd_addr_i] <= 1'b0;
      if (al_ok) pend[alloc_addr_i] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state == CLEAR) mem[cnt] <= '0;
      else if (wr_ok) mem[rd_addr_i] <= rd_data_i;
    end
  end

  assign ready_o = (state == READY);

  always_comb begin
    rs1_data_o = '0;
    rs1_pend_o = 1'b0;
    if ((state == READY) && !(ZERO && (rs1_addr_i == '0))) begin
      rs1_data_o = mem[rs1_addr_i];
      rs1_pend_o = pend[rs1_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (reg_write_i && (rd_addr_i == rs1_addr_i)) begin
        rs1_data_o = rd_data_i;
        rs1_pend_o = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    rs2_data_o = '0;
    rs2_pend_o = 1'b0;
    if ((state == READY) && !(ZERO && (rs2_addr_i == '0))) begin
      rs2_data_o = mem[rs2_addr_i];
      rs2_pend_o = pend[rs2_addr_i];
`ifdef REGFILE_BYPASS_EN
      if (reg_write_i && (rd_addr_i == rs2_addr_i)) begin
        rs2_data_o = rd_data_i;
        rs2_pend_o = 1'b0;
      end
`endif
    end
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data width of each register.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W entries.
REQ-003 SHALL have parameter ZERO_REG, default 1; when 1, entry 0 is hardwired to zero.
REQ-004 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports rs1_addr_i, rs2_addr_i  input  ADDR_W  read-port addresses.
REQ-007 SHALL have ports rs1_data_o, rs2_data_o  output  DATA_W  read-port data, combinational from address.
REQ-008 SHALL have ports rs1_pend_o, rs2_pend_o  output  1  addressed register has an outstanding producer.
REQ-009 SHALL have ports rd_addr_i  input  ADDR_W,  rd_data_i  input  DATA_W,  reg_write_i  input  1  write port.
REQ-010 SHALL have ports alloc_i  input  1,  alloc_addr_i  input  ADDR_W  mark a register pending (scoreboard).
REQ-011 SHALL have port ready_o  output  1  initialisation complete; writes/allocs accepted.

Function
REQ-012 SHALL implement a two-state FSM: CLEAR, READY.
REQ-013 In CLEAR, SHALL write zero to entry cnt each cycle, cnt counting 0 .. 2**ADDR_W-1, then go to READY.
REQ-014 In CLEAR, SHALL hold ready_o=0, ignore reg_write_i/alloc_i, drive rsN_data_o=0 and rsN_pend_o=0.
REQ-015 In READY, SHALL hold ready_o=1 and remain in READY until rst_i.
REQ-016 In READY, reg_write_i=1 SHALL store rd_data_i to entry rd_addr_i at the rising edge and clear its pending bit.
REQ-017 In READY, alloc_i=1 SHALL set the pending bit of alloc_addr_i at the rising edge.
REQ-018 Write and alloc to the same address in the same cycle: data SHALL be stored and pending bit SHALL end set (alloc wins).
REQ-019 ZERO_REG=1: writes/allocs to entry 0 SHALL be dropped; reads of entry 0 SHALL return 0 with pend 0.
REQ-020 Both read ports SHALL be independent; same address on both SHALL return identical data.
REQ-021 Stored data SHALL be exactly DATA_W bits; no sign/zero extension or truncation internally.

Reset
REQ-022 rst_i=1 at a rising edge SHALL set FSM=CLEAR, cnt=0, all pending bits=0, ready_o=0.
REQ-023 rst_i asserted mid-CLEAR or mid-operation SHALL restart clearing from entry 0; in-flight write/alloc that cycle discarded.
REQ-024 ready_o SHALL first read 1 after exactly 2**ADDR_W rising edges with rst_i=0 following reset (32 for default).

Configuration
REQ-025 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-026 With REGFILE_BYPASS_EN defined: in READY, if reg_write_i=1 and rsN_addr_i==rd_addr_i (nonzero when ZERO_REG=1), rsN_data_o SHALL equal rd_data_i and rsN_pend_o SHALL be 0 in the same cycle.
REQ-027 Without REGFILE_BYPASS_EN: rsN_data_o/rsN_pend_o SHALL reflect stored state only; written value visible the cycle after the write edge.

Verification
REQ-028 Reset then idle -> ready_o=0 for 32 cycles, 1 on cycle 33; read all 32 addresses -> all 0x00000000, pend 0.
REQ-029 Write x5=0xDEADBEEF, next cycle read rs1=5, rs2=5 -> both 0xDEADBEEF; write x0=0x12345678 -> read x0 returns 0.
REQ-030 alloc x7; next cycle rs1=7 -> pend 1; write x7=0xA5A5A5A5 -> next cycle pend 0, data 0xA5A5A5A5; alloc+write x8 same cycle -> pend 1, data updated.
REQ-031 Same-cycle write x9=0x0000CAFE and read rs1=9 -> 0x0000CAFE with REGFILE_BYPASS_EN, prior value (0) without.
REQ-032 Assert rst_i at CLEAR cnt=10 after x3 holds 0x1 -> ready_o drops, 32 further cycles to ready, x3 reads 0.
REQ-033 Write during CLEAR (x4=0xFFFFFFFF at cnt=2) -> ignored; after ready x4 reads 0.
